// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter.
// Bytes written by the host are queued in a DEPTH-entry circular FIFO. They are
// sent LSB first as start(0), data[7:0], stop(1). Each bit lasts max(baud_cnt, 4)
// clocks. The bit period is latched when a frame is loaded.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   baud_cnt  clocks per bit (values below 4 are treated as 4)
//   wr_en     push wr_data into the FIFO (ignored while full)
//   wr_data   byte to transmit
//   full      FIFO holds DEPTH entries (registered)
//   empty     FIFO holds no entries (registered)
//   TX        serial line, idles high (registered)
//   busy      a frame is in progress
//   tx_done   one-cycle pulse after the end of each stop bit
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] baud_cnt,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  output logic        full,
  output logic        empty,
  output logic        TX,
  output logic        busy,
  output logic        tx_done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic            wr_ok, pop, shift, done;
  logic [15:0]     n_eff, n_reg, timer;
  logic [3:0]      bit_cnt;
  logic [8:0]      shift_reg;
  logic            bit_end;

  assign wr_ok   = wr_en && !full;
  assign n_eff   = (baud_cnt < 16'd4) ? 16'd4 : baud_cnt;
  assign bit_end = (timer == n_reg - 16'd1);

  // FIFO occupancy
  always_comb begin
    count_nxt = count;
    unique case ({wr_ok, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    shift     = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (bit_end) begin
          if (bit_cnt == 4'd9) begin
            done = 1'b1;
            if (!empty) pop = 1'b1;
            else        state_nxt = IDLE;
          end else begin
            shift = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. TX is a separate register tracking the bit that shift_reg[0]
  // holds after this edge, so that it can reset high while shift_reg resets to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer     <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      n_reg     <= '0;
      TX        <= 1'b1;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= done;
      if (pop) begin
        shift_reg <= {mem[rd_ptr], 1'b0};
        TX        <= 1'b0;
        timer     <= '0;
        bit_cnt   <= '0;
        n_reg     <= n_eff;
        busy      <= 1'b1;
      end else if (shift) begin
        shift_reg <= {1'b1, shift_reg[8:1]};
        TX        <= shift_reg[1];
        timer     <= '0;
        bit_cnt   <= bit_cnt + 4'd1;
      end else if (done) begin
        TX      <= 1'b1;
        busy    <= 1'b0;
        timer   <= '0;
        bit_cnt <= '0;
      end else if (state == SEND) begin
        timer <= timer + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: table of single-frame vectors plus hand-written
// sequences for burst/overflow, baud change, reset mid-frame and wrap-around.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] baud_cnt;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        full, empty, TX, busy, tx_done;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  uart_tx_fifo #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud_cnt (baud_cnt),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .TX       (TX),
    .busy     (busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  data;
    logic [15:0] baud;
    int          n;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Checks every cycle of a frame whose load edge has just passed (caller sits
  // on the negedge before the first start-bit sample). With skip set, the first
  // cycle was already checked as the previous frame's done cycle.
  task automatic frame(input logic [7:0] d, input int n, input bit skip,
                       input bit more, input string tag);
    logic [9:0] bits;
    bits = {1'b1, d, 1'b0};
    for (int i = (skip ? 1 : 0); i < 10 * n; i++) begin
      @(negedge clk);
      chk($sformatf("%s cyc%0d {done,busy,tx}", tag, i), {tx_done, busy, TX},
          {1'b0, 1'b1, bits[i / n]});
    end
    @(negedge clk);
    chk({tag, " end {done,busy,tx}"}, {tx_done, busy, TX}, {1'b1, more, !more});
  endtask

  // Receiver model: finds a start bit, samples mid-bit.
  task automatic rx_byte(input int n, output logic [7:0] d, output logic start_ok,
                         output logic stop);
    int t;
    t = 0;
    d = '0;
    while (TX !== 1'b0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    start_ok = 1'b0;
    stop     = 1'b0;
    if (t < 500) begin
      repeat (n / 2) @(negedge clk);
      start_ok = (TX === 1'b0);
      for (int k = 0; k < 8; k++) begin
        repeat (n) @(negedge clk);
        d[k] = TX;
      end
      repeat (n) @(negedge clk);
      stop = TX;
    end
  endtask

  vec_t vecs [6];

  initial begin
    logic [7:0] rxd;
    logic       s_ok, st;
    int         bad;

    vecs[0] = '{data: 8'hA5, baud: 16'd16, n: 16};
    vecs[1] = '{data: 8'hFF, baud: 16'd1,  n: 4};
    vecs[2] = '{data: 8'h00, baud: 16'd0,  n: 4};
    vecs[3] = '{data: 8'h3C, baud: 16'd3,  n: 4};
    vecs[4] = '{data: 8'h81, baud: 16'd4,  n: 4};
    vecs[5] = '{data: 8'h5A, baud: 16'd5,  n: 5};

    rst_n    = 1'b1;
    baud_cnt = 16'd16;
    wr_en    = 1'b0;
    wr_data  = '0;
    #2 rst_n = 1'b0;
    #1 chk("in reset {full,empty,busy,done,tx}", {full, empty, busy, tx_done, TX}, 5'b01001);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after reset {full,empty,busy,done,tx}", {full, empty, busy, tx_done, TX}, 5'b01001);

    // Single-frame vectors
    for (int v = 0; v < 6; v++) begin
      baud_cnt = vecs[v].baud;
      wr_data  = vecs[v].data;
      wr_en    = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      chk($sformatf("vec%0d after write {empty,busy,tx}", v), {empty, busy, TX}, 3'b001);
      frame(vecs[v].data, vecs[v].n, 1'b0, 1'b0, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d empty at end", v), empty, 1'b1);
    end

    // Burst of 5 plus one dropped write
    baud_cnt = 16'd8;
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          wr_data = 8'(i);
          wr_en   = 1'b1;
          @(negedge clk);
          if (i >= 5) chk($sformatf("burst full after write %0d", i), full, 1'b1);
        end
        wr_en = 1'b0;
      end
      begin
        @(negedge clk);
        frame(8'h01, 8, 1'b0, 1'b1, "burst1");
        frame(8'h02, 8, 1'b1, 1'b1, "burst2");
        frame(8'h03, 8, 1'b1, 1'b1, "burst3");
        frame(8'h04, 8, 1'b1, 1'b1, "burst4");
        frame(8'h05, 8, 1'b1, 1'b0, "burst5");
        chk("burst empty at end", empty, 1'b1);
      end
    join
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (TX !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("burst no sixth frame", bad, 0);

    // Baud change mid-frame
    baud_cnt = 16'd10;
    fork
      begin
        wr_data = 8'h55;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_data = 8'h33;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (33) @(negedge clk);
        baud_cnt = 16'd20;
      end
      begin
        @(negedge clk);
        frame(8'h55, 10, 1'b0, 1'b1, "baud1");
        frame(8'h33, 20, 1'b1, 1'b0, "baud2");
      end
    join

    // Reset during data bit 3 with two bytes queued
    baud_cnt = 16'd8;
    wr_en    = 1'b1;
    wr_data  = 8'hC3;
    @(negedge clk);
    wr_data = 8'h11;
    @(negedge clk);
    wr_data = 8'h22;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (33) @(negedge clk);
    chk("rst-mid tx in data bit3", {busy, TX}, 2'b10);
    chk("rst-mid queued flags {full,empty}", {full, empty}, 2'b00);
    #2 rst_n = 1'b0;
    #1 chk("rst-mid async {full,empty,busy,done,tx}", {full, empty, busy, tx_done, TX}, 5'b01001);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (TX !== 1'b1 || busy !== 1'b0 || empty !== 1'b1) bad++;
    end
    chk("rst-mid nothing sent after release", bad, 0);
    baud_cnt = 16'd4;
    wr_data  = 8'h7E;
    wr_en    = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    frame(8'h7E, 4, 1'b0, 1'b0, "post-rst");

    // Wrap-around: 10 bytes written whenever not full
    baud_cnt = 16'd4;
    fork
      begin
        int k, guard;
        k = 0;
        guard = 0;
        while (k < 10 && guard < 2000) begin
          if (!full) begin
            wr_data = 8'h30 + 8'(k);
            wr_en   = 1'b1;
            k++;
          end else begin
            wr_en = 1'b0;
          end
          @(negedge clk);
          guard++;
        end
        wr_en = 1'b0;
        chk("wrap all writes issued", k, 10);
      end
      begin
        for (int j = 0; j < 10; j++) begin
          rx_byte(4, rxd, s_ok, st);
          chk($sformatf("wrap rx byte %0d {start,stop,data}", j), {s_ok, st, rxd},
              {1'b1, 1'b1, 8'h30 + 8'(j)});
        end
      end
    join
    repeat (4) @(negedge clk);
    chk("wrap idle at end {empty,busy,tx}", {empty, busy, TX}, 3'b101);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter for the logic-analyzer command/response link. It is the transmit-side counterpart of the trigger-capable UART receiver. It accepts bytes from the host-side command logic into a small FIFO and serialises them on TX as 8N1 frames at a run-time programmable bit period. The `baud_cnt` input is shared with the receiver, so both directions run at the same rate.

## Interface
- DEPTH, 4, FIFO entries; power of 2, legal range 2–16.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- baud_cnt  in  16  clocks per bit; values 0–3 are treated as 4.
- wr_en  in  1  push `wr_data` into the FIFO on this edge.
- wr_data  in  8  byte to transmit.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- TX  out  1  serial line; idles high; registered output.
- busy  out  1  a frame is in progress (start bit through stop bit).
- tx_done  out  1  one-cycle pulse at the end of each stop bit.

## Operation
- **FIFO**
  - Circular buffer with read pointer, write pointer and occupancy count. The count is $clog2(DEPTH)+1 bits wide.
  - A write is accepted when `wr_en` is high and `full` is low.
  - A write while `full` is high is dropped silently, even if a pop occurs on the same edge.
  - Pointers wrap modulo DEPTH.
  - A pop never occurs while `empty` is high, so a write and a pop in the same cycle only happens with count ≥ 1. In that case count is unchanged and both pointers advance.
- **Frame format:** start bit 0, data[0]..data[7] (LSB first), stop bit 1. 10 bits total.
- **Bit timing:** each bit lasts exactly N clocks, where N = max(baud_cnt, 4).
  - N is latched into an internal register when a frame is loaded.
  - Changes to `baud_cnt` mid-frame do not affect the current frame.
- **Datapath:**
  - 16-bit bit-timer counts 0..N-1.
  - 4-bit bit counter counts 0..9.
  - 9-bit shift register is loaded with {data, 0}. It shifts right with 1 fill; TX = shift_reg[0].
- **State machine:**
  - IDLE:
    - TX = 1, busy = 0.
    - If !empty: pop the FIFO head, load the shift register, clear the timers, set busy, and go to SEND.
  - SEND:
    - The bit-timer increments each clock.
    - When the timer reaches N-1 with bit_cnt < 9: shift, increment bit_cnt, and clear the timer.
    - When the timer reaches N-1 with bit_cnt == 9 (end of stop bit): assert tx_done for 1 cycle.
      - If !empty: pop and load the next frame immediately (no idle gap); stay in SEND with busy held high.
      - Otherwise: go to IDLE with busy low.
- **Reset values:** TX=1, busy=0, tx_done=0, full=0, empty=1. Pointers, count, timers and shift register are 0; state is IDLE.
- **Reset mid-frame:** TX returns high asynchronously and all FIFO contents are discarded.

## Timing
- **Write-to-start latency:** `wr_en` sampled at edge E with the FIFO empty and the block idle.
  - `empty` falls after E.
  - The pop occurs at E+1; TX is low and busy is high after E+1.
- **Frame length:** 10·N clocks.
  - The start bit occupies edges E+1..E+1+N.
  - data[k] begins at edge E+1+(k+1)·N.
  - The stop bit ends at edge E+1+10·N.
  - tx_done is high for the one cycle following that edge.
- **Back-to-back frames:** the next start bit begins on the same edge tx_done rises. TX goes 1→0 with no extra high cycle beyond the N-clock stop bit.
- **Flag timing:** `full` and `empty` are registered and reflect the occupancy after each edge. A pop makes `full` fall the cycle after the pop.
- **Throughput:** one byte per 10·N clocks. Host writes are non-blocking while `full` is low.

## Test plan
- **Single byte:** reset, baud_cnt=16, write 0xA5 → TX low for 16 clocks, then bits 1,0,1,0,0,1,0,1 at 16 clocks each, then 16 clocks high. tx_done pulses once, 161 clocks after the write edge; busy drops the same cycle.
- **Burst and overflow:** baud_cnt=8, write 0x01,0x02,0x03,0x04,0x05 on consecutive cycles with DEPTH=4.
  - 0x01 is popped at once, so 0x02–0x05 fit; a sixth write 0x06 while `full` is dropped.
  - Bytes 01..05 appear back to back with no idle gap between stop and start bits.
  - 5 tx_done pulses, 80 clocks apart; `empty` is high at the end.
- **Baud change mid-frame:** start 0x55 at baud_cnt=10 and switch to 20 after 3 bits → the current frame keeps 10-clock bits; the next queued byte uses 20-clock bits.
- **Minimum clamp:** baud_cnt=1 with byte 0xFF → each bit lasts 4 clocks; the frame is 40 clocks.
- **Reset mid-frame:** assert rst_n low during data bit 3 with 2 bytes queued → TX=1, busy=0, empty=1 immediately. After release, no further frames are sent until a new write.
- **Wrap-around:** 10 sequential bytes 0x30..0x39, written whenever !full → pointers wrap twice and all 10 bytes are received in order by a UART receiver model.
